// File: rtl/spi_master.sv
// spi_master: single-byte SPI master, all four CPOL/CPHA modes; define SPIM_LOOPBACK_EN to sample the registered mosi instead of miso; ports clk/reset, start/cpol/cpha/tx_data in, miso in, sclk/ss_n/mosi out, busy/rx_valid/rx_data out
module spi_master #(
  parameter int CLK_DIV = 4,
  parameter int DATA_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              cpol,
  input  logic              cpha,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              miso,
  output logic              sclk,
  output logic              ss_n,
  output logic              mosi,
  output logic              busy,
  output logic              rx_valid,
  output logic [DATA_W-1:0] rx_data
);
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int EW = $clog2(2 * DATA_W);
  typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, DONE} state_t;
  state_t state_q;
  logic [CW-1:0] cnt_q;
  logic [EW-1:0] edge_q;
  logic cpha_q, sclk_q, ss_n_q, mosi_q, busy_q, rx_valid_q;
  logic [DATA_W-1:0] tx_q, rx_q, rx_data_q;
  logic div_end, samp, shft, sin;
  always_comb begin
    div_end = cnt_q == CW'(CLK_DIV - 1);
    samp = div_end && (edge_q[0] == cpha_q);
    shft = div_end && (edge_q[0] != cpha_q) && (edge_q != EW'(2 * DATA_W - 1));
`ifdef SPIM_LOOPBACK_EN
    sin = mosi_q;
`else
    sin = miso;
`endif
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      edge_q     <= '0;
      cpha_q     <= 1'b0;
      sclk_q     <= 1'b0;
      ss_n_q     <= 1'b1;
      mosi_q     <= 1'b0;
      busy_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      tx_q       <= '0;
      rx_q       <= '0;
      rx_data_q  <= '0;
    end else begin
      rx_valid_q <= 1'b0;
      cnt_q <= (state_q == IDLE || div_end) ? '0 : cnt_q + 1'b1;
      case (state_q)
        IDLE: begin
          sclk_q <= cpol;
          if (start) begin
            state_q <= SETUP;
            ss_n_q  <= 1'b0;
            busy_q  <= 1'b1;
            cpha_q  <= cpha;
            edge_q  <= '0;
            // CPHA=0 presents the first bit before the first edge
            mosi_q  <= cpha ? mosi_q : tx_data[DATA_W-1];
            tx_q    <= cpha ? tx_data : tx_data << 1;
          end
        end
        SETUP: state_q <= div_end ? XFER : SETUP;
        XFER: begin
          if (div_end) begin
            sclk_q  <= ~sclk_q;
            edge_q  <= edge_q + 1'b1;
            state_q <= (edge_q == EW'(2 * DATA_W - 1)) ? HOLD : XFER;
          end
          if (samp) rx_q <= {rx_q[DATA_W-2:0], sin};
          if (shft) begin
            mosi_q <= tx_q[DATA_W-1];
            tx_q   <= tx_q << 1;
          end
        end
        HOLD: begin
          if (div_end) begin
            state_q    <= DONE;
            rx_valid_q <= 1'b1;
            rx_data_q  <= rx_q;
          end
        end
        DONE: begin
          state_q <= IDLE;
          ss_n_q  <= 1'b1;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign sclk     = sclk_q;
  assign ss_n     = ss_n_q;
  assign mosi     = mosi_q;
  assign busy     = busy_q;
  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;
endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: directed self-checking bench for spi_master with a behavioural SPI slave
module tb_spi_master;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, cpol = 1'b0, cpha = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic miso_w, sclk, ss_n, mosi, busy, rx_valid;
  logic [7:0] rx_data;
  int vec = 0, miss = 0, nfall = 0, nvalid = 0;
  logic [7:0] s_tx = 8'h00, s_sh = 8'h00, s_rx = 8'h00;
  logic s_cpol = 1'b0, s_cpha = 1'b0, s_miso = 1'b0, ss_p = 1'b1, sclk_p = 1'b0;
  spi_master dut (
    .clk(clk), .reset(reset), .start(start), .cpol(cpol), .cpha(cpha),
    .tx_data(tx_data), .miso(miso_w), .sclk(sclk), .ss_n(ss_n), .mosi(mosi),
    .busy(busy), .rx_valid(rx_valid), .rx_data(rx_data)
  );
`ifdef SPIM_LOOPBACK_EN
  assign miso_w = 1'b0;
`else
  assign miso_w = s_miso;
`endif
  always #5 clk = ~clk;
  always @(negedge ss_n) nfall++;
  always @(posedge clk) if (rx_valid === 1'b1) nvalid++;
  always @(ss_n, sclk) begin
    if (ss_p === 1'b1 && ss_n === 1'b0) begin
      s_sh = s_tx;
      if (!s_cpha) begin
        s_miso = s_sh[7];
        s_sh = s_sh << 1;
      end
    end else if (ss_n === 1'b0 && sclk !== sclk_p) begin
      if ((sclk != s_cpol) ^ s_cpha) s_rx = {s_rx[6:0], mosi};
      else begin
        s_miso = s_sh[7];
        s_sh = s_sh << 1;
      end
    end
    ss_p = ss_n;
    sclk_p = sclk;
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [7:0] exp_rx(input logic [7:0] tx, input logic [7:0] srx);
`ifdef SPIM_LOOPBACK_EN
    return tx;
`else
    return srx;
`endif
  endfunction
  task automatic run(input logic pol, input logic pha, input logic [7:0] tx, input logic [7:0] srx, input bit glitch);
    int lat, tog;
    logic prev;
    cpol = pol; cpha = pha; tx_data = tx;
    s_cpol = pol; s_cpha = pha; s_tx = srx;
    tick; tick;
    chk("idle_sclk", sclk, pol);
    start = 1'b1; tick; start = 1'b0;
    tx_data = ~tx; cpha = ~pha;
    chk("ss_n_T1", ss_n, 0);
    chk("busy_T1", busy, 1);
    lat = 1; tog = 0; prev = sclk;
    while (rx_valid !== 1'b1 && lat < 200) begin
      if (glitch && (lat == 10 || lat == 72)) start = 1'b1;
      tick; start = 1'b0; lat++;
      if (sclk !== prev) tog++;
      prev = sclk;
    end
    chk("latency", lat, 73);
    chk("sclk_edges", tog, 16);
    chk("rx_data", rx_data, exp_rx(tx, srx));
    chk("mosi_bits", s_rx, tx);
    chk("end_sclk", sclk, pol);
    cpha = pha;
    tick;
    chk("busy_off", busy, 0);
    chk("ss_n_off", ss_n, 1);
    chk("rx_valid_pulse", rx_valid, 0);
  endtask
  initial begin
    int f0, v0, lat, gap;
    tick; tick;
    chk("rst_sclk", sclk, 0);
    chk("rst_ss_n", ss_n, 1);
    chk("rst_mosi", mosi, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_rx_data", rx_data, 0);
    reset = 1'b0;
    run(1'b0, 1'b0, 8'hA5, 8'h3C, 1'b0);
    run(1'b0, 1'b1, 8'h81, 8'h7E, 1'b0);
    run(1'b1, 1'b0, 8'h81, 8'h7E, 1'b0);
    run(1'b1, 1'b1, 8'h81, 8'h7E, 1'b0);
    f0 = nfall; v0 = nvalid;
    run(1'b0, 1'b0, 8'h96, 8'h5A, 1'b1);
    repeat (10) tick;
    chk("glitch_ss_falls", nfall - f0, 1);
    chk("glitch_rx_valids", nvalid - v0, 1);
    cpol = 1'b0; cpha = 1'b0; tx_data = 8'hF0; s_cpol = 1'b0; s_cpha = 1'b0; s_tx = 8'h0F;
    tick;
    start = 1'b1; tick; start = 1'b0;
    repeat (29) tick;
    v0 = nvalid;
    reset = 1'b1; tick; reset = 1'b0;
    chk("rst_mid_ss_n", ss_n, 1);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_sclk", sclk, 0);
    repeat (80) tick;
    chk("rst_mid_no_valid", nvalid - v0, 0);
    run(1'b0, 1'b0, 8'h55, 8'hAA, 1'b0);
    cpol = 1'b0; cpha = 1'b1; tx_data = 8'h3C; s_cpol = 1'b0; s_cpha = 1'b1; s_tx = 8'hC3;
    tick;
    start = 1'b1; tick;
    lat = 1;
    while (rx_valid !== 1'b1 && lat < 200) begin tick; lat++; end
    chk("b2b_latency", lat, 73);
    tick;
    chk("b2b_gap_ss_n", ss_n, 1);
    chk("b2b_gap_busy", busy, 0);
    tick;
    chk("b2b_restart_ss_n", ss_n, 0);
    gap = 2;
    while (rx_valid !== 1'b1 && gap < 200) begin tick; gap++; end
    start = 1'b0;
    chk("b2b_spacing", gap, 74);
    chk("b2b_rx_data", rx_data, exp_rx(8'h3C, 8'hC3));
    tick; tick;
    chk("b2b_stop_ss_n", ss_n, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
